// File: rtl/rv32_mem_pkg.sv
// Shared load/store definitions: RV32I funct3 access codes, responder FSM states
// and the byte-enable width, used by the responder and by the core's LSU.
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } mem_state_e;

    // Only the five encodings above are legal; unsigned variants are loads only.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: f3_illegal = 1'b0;
            F3_BU, F3_HU:     f3_illegal = we;
            default:          f3_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// Word-wide data SRAM: byte-enable synchronous write, synchronous read with a
// registered output that only changes on a read.
module dmem_sram_bank
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array and its read register have no reset so they map onto a
    // real SRAM macro; contents survive rst, matching how the core expects dmem.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory slave: accepts one load/store, waits WAIT_CYC cycles,
// accesses the SRAM bank and holds an aligned, extended response until consumed.
module dmem_responder
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYC    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WAIT_LAST = 3'((WAIT_CYC == 0) ? 0 : WAIT_CYC - 1);

    mem_state_e state, state_nxt;

    logic [AW-1:0]   idx_q;
    logic [1:0]      lane_q;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [31:0]     wdata_q;
    logic            err_q;
    logic [2:0]      wait_cnt;

    logic            accept;
    logic            req_err;
    logic            sram_en;
    logic [BE_W-1:0] sram_be;
    logic [31:0]     sram_wdata;
    logic [31:0]     sram_rdata;
    logic [31:0]     shifted;
    logic [31:0]     load_val;

    assign accept = req_valid & req_ready;

    // Any address at or beyond the array end is an error, not a wrap.
    always_comb begin
        req_err = f3_illegal(req_funct3, req_we);
        if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
            req_err = 1'b1;
        if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if ((req_addr >> (AW + 2)) != 32'd0)
            req_err = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  wait_cnt <= '0;
        else if (state != ST_WAIT) wait_cnt <= '0;
        else                       wait_cnt <= wait_cnt + 3'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            lane_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= F3_W;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            idx_q   <= req_addr[AW+1:2];
            lane_q  <= req_addr[1:0];
            we_q    <= req_we;
            f3_q    <= req_funct3;
            wdata_q <= req_wdata;
            err_q   <= req_err;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = (WAIT_CYC == 0) ? ST_ACCESS : ST_WAIT;
            ST_WAIT:   if (wait_cnt == WAIT_LAST) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   if (resp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        resp_err   = (state == ST_RESP) && err_q;
        sram_en    = (state == ST_ACCESS) && !err_q;
        resp_rdata = (state == ST_RESP && !err_q && !we_q) ? load_val : 32'd0;
    end

    // Store lanes: narrow data is replicated so the byte enables pick the lane.
    always_comb begin
        sram_be    = 4'hF;
        sram_wdata = wdata_q;
        case (f3_q)
            F3_B: begin
                sram_be    = 4'b0001 << lane_q;
                sram_wdata = {4{wdata_q[7:0]}};
            end
            F3_H: begin
                sram_be    = 4'b0011 << lane_q;
                sram_wdata = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = sram_rdata >> {lane_q, 3'b000};

    always_comb begin
        load_val = shifted;
        case (f3_q)
            F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_val = {24'd0, shifted[7:0]};
            F3_HU:   load_val = {16'd0, shifted[15:0]};
            default: ;
        endcase
    end

    dmem_sram_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_bank (
        .clk  (clk),
        .en   (sram_en),
        .we   (we_q),
        .be   (sram_be),
        .idx  (idx_q),
        .wdata(sram_wdata),
        .rdata(sram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, stall/reset sequences and
// randomized traffic against a byte-array memory model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WC    = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYC(WC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] model_mem [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting on handshake", name);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge consuming the response.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
        int guard = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        if (guard >= 50) timeout("accept");
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (lat >= 50) timeout("resp_valid");
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    // Reference model: memory as bytes, results from the access rules directly.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int size;
        longint val;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        er = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (we && f3[2])
             || (addr % size != 0) || (longint'(addr) >= 4 * DEPTH);
        rd = 32'd0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < size; i++) model_mem[addr + i] = wdata[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < size; i++) val += longint'(model_mem[addr + i]) << (8 * i);
                if (!f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                    val -= longint'(1) << (8 * size);
                rd = 32'(val);
            end
        end
    endtask

    initial begin
        logic [31:0] rd, exp_rd, held;
        logic        er, exp_er;
        int          lat;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wd;

        vecs.push_back('{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFFFFDE, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 32'h103, 32'h0,        32'h000000DE, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFFDEAD, 1'b0});
        vecs.push_back('{1'b0, 3'b101, 32'h100, 32'h0,        32'h0000BEEF, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h100, 32'h0,        32'hFFFFFFEF, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 32'h101, 32'h0,        32'h000000BE, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 32'h101, 32'hAAAAAA55, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEAD55EF, 1'b0});
        vecs.push_back('{1'b1, 3'b001, 32'h102, 32'hFFFF1234, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        32'h123455EF, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 3'b010, 32'h102, 32'h11111111, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 3'b010, 32'h1000, 32'h0,       32'h0,        1'b1});
        vecs.push_back('{1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 3'b101, 32'h100, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 3'b110, 32'h100, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 3'b010, 32'h1000, 32'h22222222, 32'h0,       1'b1});
        vecs.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        32'h123455EF, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h102, 32'h0,        32'h00001234, 1'b0});

        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready",  32'(req_ready),  32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_err",   32'(resp_err),   32'd0);
        check("reset resp_rdata", resp_rdata,      32'd0);
        rst = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("spurious resp_ready", 32'(resp_valid), 32'd0);
        resp_ready = 1'b0;

        foreach (vecs[i]) begin
            txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(1 + WC));
        end

        // Stall: response held 5 cycles while a second request waits.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk); #1;
        req_funct3 = 3'b100; req_addr = 32'h103;
        lat = 0;
        while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (lat >= 50) timeout("stall resp_valid");
        held = resp_rdata;
        check("stall first rdata", held, 32'h123455EF);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d resp_valid", c), 32'(resp_valid), 32'd1);
            check($sformatf("stall%0d rdata", c), resp_rdata, 32'h123455EF);
            check($sformatf("stall%0d req_ready", c), 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("stall exit req_ready", 32'(req_ready), 32'd1);
        check("stall exit resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (lat >= 50) timeout("stall second resp");
        check("stall second rdata", resp_rdata, 32'h00000012);
        check("stall second latency", 32'(lat), 32'(1 + WC));
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Reset while an error response is pending.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 32'h100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (lat >= 50) timeout("reset pending resp");
        check("pre-reset resp_err", 32'(resp_err), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midresp req_ready",  32'(req_ready),  32'd1);
        check("midresp resp_valid", 32'(resp_valid), 32'd0);
        check("midresp resp_err",   32'(resp_err),   32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat);
        check("post-reset sram kept", rd, 32'h123455EF);

        // Randomized traffic in the low 256 bytes, plus some out-of-range addresses.
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            model(1'b1, 3'b010, 32'(4 * w), wd, exp_rd, exp_er);
            txn(1'b1, 3'b010, 32'(4 * w), wd, rd, er, lat);
            check($sformatf("fill%0d err", w), 32'(er), 32'(exp_er));
        end
        for (int n = 0; n < 400; n++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            wd   = $urandom;
            case ($urandom_range(0, 9))
                0:       addr = 32'(4 * DEPTH + $urandom_range(0, 15));
                1:       addr = $urandom | 32'h8000_0000;
                default: addr = 32'($urandom_range(0, 252));
            endcase
            model(we, f3, addr, wd, exp_rd, exp_er);
            txn(we, f3, addr, wd, rd, er, lat);
            check($sformatf("rnd%0d rdata a=%h f3=%0d we=%0d", n, addr, f3, we), rd, exp_rd);
            check($sformatf("rnd%0d err", n), 32'(er), 32'(exp_er));
            check($sformatf("rnd%0d latency", n), 32'(lat), 32'(1 + WC));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
